interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port irq_src, input, 6 bits: interrupt sources; bit0 Timer0 IRQ, bit1 Timer1 IRQ, bit2 external interrupt, bits5:3 spare.
REQ-004 The block SHALL have port Addr, input, 2 bits: register select from the bridge, word address bits [3:2].
REQ-005 The block SHALL have port WE, input, 1 bit: register write enable.
REQ-006 The block SHALL have port Din, input, 32 bits: register write data.
REQ-007 The block SHALL have port Dout, output, 32 bits: combinational register read data for Addr.
REQ-008 The block SHALL have port ack, input, 1 bit: CPU exception-entry acknowledge.
REQ-009 The block SHALL have port eret, input, 1 bit: CPU handler-return pulse.
REQ-010 The block SHALL have port HWInt, output, 6 bits: one-hot request to CPU; only the granted source bit is set.
REQ-011 The block SHALL have port irq_id, output, 3 bits: index of the granted or in-service source.

Function
REQ-012 Register map SHALL be: Addr 0 MASK[5:0] (RW, 1 = enabled); Addr 1 PENDING[5:0] (R, write-1-to-clear for edge-mode bits); Addr 2 STATUS {state[1:0] at [5:4], irq_id at [2:0]} (R); Addr 3 MODE[5:0] (RW, 1 = edge, 0 = level); unused Dout bits read 0.
REQ-013 Writes to STATUS, and W1C writes to level-mode PENDING bits, SHALL be ignored.
REQ-014 Sample s[i] SHALL be irq_src[i] as seen at the clock edge, or its synchronised copy (see Configuration).
REQ-015 A level-mode PENDING bit SHALL equal the previous cycle's s[i]; an edge-mode bit SHALL set on a 0->1 transition of s[i] and stay set until it is cleared.
REQ-016 An edge-mode PENDING bit SHALL be cleared by a W1C write or by an ack granting that source; a new edge in the same cycle SHALL win.
REQ-017 Eligible set SHALL be PENDING & MASK; priority is fixed, lowest index highest.
REQ-018 FSM states SHALL be IDLE(00), REQ(01), SERV(10).
REQ-019 IDLE -> REQ SHALL occur at the edge where the eligible set is nonzero; irq_id latches the highest-priority eligible source at that edge.
REQ-020 In REQ, HWInt SHALL equal 1<<irq_id; in IDLE and SERV, HWInt SHALL be 0.
REQ-021 In REQ, irq_id SHALL be stable; a newly eligible higher-priority source SHALL not preempt.
REQ-022 REQ -> SERV SHALL occur on ack; REQ -> IDLE (withdraw) SHALL occur when the granted bit becomes ineligible without ack; ack SHALL win if both occur.
REQ-023 SERV -> IDLE SHALL occur on eret; nesting SHALL not be supported; ack is ignored outside REQ; eret is ignored outside SERV.
REQ-024 Latency SHALL be: source pending at edge k, then HWInt high after edge k+1; after eret the next grant is no earlier than two edges later.

Reset
REQ-025 While reset is low, the block SHALL hold state=IDLE, MASK=0, MODE=0, PENDING=0, edge history=0, synchroniser flops=0, irq_id=0, HWInt=0; Dout SHALL reflect these values.
REQ-026 Reset asserted in REQ or SERV SHALL abort immediately and asynchronously; no grant SHALL survive reset.
REQ-027 The first grant after reset deassertion SHALL require a fresh MASK write.

Configuration
REQ-028 Macro INTERRUPT_CTRL_SYNC_EN defined: each irq_src bit SHALL pass a 2-flop synchroniser before sampling, adding 2 cycles to REQ-024 latency.
REQ-029 Macro INTERRUPT_CTRL_SYNC_EN undefined: irq_src SHALL be sampled directly, with no synchroniser flops present.

Verification
REQ-030 Bench SHALL check: MASK=0x07, MODE=0, irq_src=0x02 held -> HWInt=0x02, irq_id=1 two edges later; ack -> HWInt=0, STATUS=0x21; eret -> IDLE, re-grant of source 1.
REQ-031 Bench SHALL check: irq_src=0x06 simultaneously with MASK=0x07 -> irq_id=1 granted; irq_src[0] rising while in REQ -> irq_id stays 1 until ack.
REQ-032 Bench SHALL check: MODE=0x04, MASK=0x04, one-cycle pulse on irq_src[2] -> PENDING=0x04 latched, grant id 2; ack -> PENDING=0x00.
REQ-033 Bench SHALL check: level source 0 granted, then MASK written 0 before ack -> HWInt drops next edge, STATUS state=00.
REQ-034 Bench SHALL check: edge PENDING bit W1C in the same cycle as a new edge -> bit remains 1.
REQ-035 Bench SHALL check: reset pulled low mid-SERV -> HWInt=0, MASK=0, state=00 without waiting for a clock edge; with SYNC_EN defined, latency in REQ-030 is four edges.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// Six-source interrupt controller: MASK/PENDING/STATUS/MODE registers, fixed-priority
// grant FSM with ack/eret handshake. Define INTERRUPT_CTRL_SYNC_EN for 2-flop input sync.
module interrupt_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq_src,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic        ack,
  input  logic        eret,
  output logic [5:0]  HWInt,
  output logic [2:0]  irq_id
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] SERV = 2'b10;

  logic [1:0] state_r, state_nxt_s;
  logic [2:0] irq_id_r, id_nxt_s;
  logic [5:0] hwint_r, hwint_nxt_s;
  logic [5:0] mask_r, mode_r, pend_r, hist_r;
  logic [5:0] samp_s, clr_s, rise_s, elig_s, pend_nxt_s;
  logic [7:0] elig_ext_s;
  logic       din_unused_s;

  function automatic logic [2:0] lowest_set(input logic [5:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      idx = vec[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

`ifdef INTERRUPT_CTRL_SYNC_EN
  logic [5:0] sync1_r, sync2_r;

  // Two-flop synchroniser in front of the sampler
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 6'b0;
      sync2_r <= 6'b0;
    end else begin
      sync1_r <= irq_src;
      sync2_r <= sync1_r;
    end
  end

  assign samp_s = sync2_r;
`else
  assign samp_s = irq_src;
`endif

  assign din_unused_s = ^Din[31:6];

  // In REQ, hwint_r is exactly the granted source's one-hot, so it doubles as the ack clear mask
  assign clr_s      = ((WE && (Addr == 2'd1)) ? Din[5:0] : 6'b0)
                    | (((state_r == REQ) && ack) ? hwint_r : 6'b0);
  assign rise_s     = samp_s & ~hist_r;
  assign pend_nxt_s = (mode_r & ((pend_r & ~clr_s) | rise_s)) | (~mode_r & samp_s);
  assign elig_s     = pend_r & mask_r;
  assign elig_ext_s = {2'b00, elig_s};

  // Grant FSM next state; ack beats withdraw, no preemption while in REQ
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = irq_id_r;
    case (state_r)
      IDLE: begin
        if (elig_s != 6'b0) begin
          state_nxt_s = REQ;
          id_nxt_s    = lowest_set(elig_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (ack) begin
          state_nxt_s = SERV;
        end else if (!elig_ext_s[irq_id_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SERV: begin
        if (eret) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERV;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    hwint_nxt_s = (state_nxt_s == REQ) ? (6'b000001 << id_nxt_s) : 6'b0;
  end

  // Register read mux
  always_comb begin
    Dout = 32'b0;
    case (Addr)
      2'd0:    Dout = {26'b0, mask_r};
      2'd1:    Dout = {26'b0, pend_r};
      2'd2:    Dout = {26'b0, state_r, 1'b0, irq_id_r};
      2'd3:    Dout = {26'b0, mode_r};
      default: Dout = 32'b0;
    endcase
  end

  // Configuration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= 6'b0;
      mode_r <= 6'b0;
    end else begin
      if (WE && (Addr == 2'd0)) mask_r <= Din[5:0];
      if (WE && (Addr == 2'd3)) mode_r <= Din[5:0];
    end
  end

  // Pending bits, edge history and grant state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r   <= 6'b0;
      hist_r   <= 6'b0;
      state_r  <= IDLE;
      irq_id_r <= 3'd0;
      hwint_r  <= 6'b0;
    end else begin
      pend_r   <= pend_nxt_s;
      hist_r   <= samp_s;
      state_r  <= state_nxt_s;
      irq_id_r <= id_nxt_s;
      hwint_r  <= hwint_nxt_s;
    end
  end

  assign HWInt  = hwint_r;
  assign irq_id = irq_id_r;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the register/grant rules.
module tb_interrupt_ctrl;

`ifdef INTERRUPT_CTRL_SYNC_EN
  localparam int LAT  = 4;
  localparam int SYNC = 2;
`else
  localparam int LAT  = 2;
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_src;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        ack;
  logic        eret;
  logic [5:0]  HWInt;
  logic [2:0]  irq_id;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state: 0 idle, 1 requesting, 2 in service
  int         m_state, m_id;
  logic [5:0] m_mask, m_mode, m_pend, m_prev, m_sq0, m_sq1;

  interrupt_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .ack(ack), .eret(eret), .HWInt(HWInt), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_id = 0;
    m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_sq0 = '0; m_sq1 = '0;
  endtask

  function automatic logic [5:0] exp_hw();
    return (m_state == 1) ? 6'(1 << m_id) : 6'b0;
  endfunction

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {26'b0, m_mask};
      2'd1:    return {26'b0, m_pend};
      2'd2:    return {26'b0, 2'(m_state), 1'b0, 3'(m_id)};
      default: return {26'b0, m_mode};
    endcase
  endfunction

  // one rising edge of the reference: sample, pending rules, grant rules, register writes
  task automatic model_step();
    logic [5:0] s, elig, np;
    if (SYNC != 0) s = m_sq1; else s = irq_src;
    m_sq1 = m_sq0;
    m_sq0 = irq_src;
    elig = m_pend & m_mask;
    for (int i = 0; i < 6; i++) begin
      if (!m_mode[i]) np[i] = s[i];
      else if (s[i] && !m_prev[i]) np[i] = 1'b1;
      else if ((WE && Addr == 2'd1 && Din[i]) || (m_state == 1 && ack && m_id == i)) np[i] = 1'b0;
      else np[i] = m_pend[i];
    end
    m_prev = s;
    case (m_state)
      0: if (elig != 6'b0) begin
           m_state = 1;
           for (int i = 5; i >= 0; i--) if (elig[i]) m_id = i;
         end
      1: if (ack) m_state = 2; else if (!elig[m_id]) m_state = 0;
      default: if (eret) m_state = 0;
    endcase
    if (WE && Addr == 2'd0) m_mask = Din[5:0];
    if (WE && Addr == 2'd3) m_mode = Din[5:0];
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("hwint", 32'(HWInt), 32'(exp_hw()));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("dout", Dout, exp_dout(Addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; WE = 1'b1; Din = d;
    tick();
    WE = 1'b0; Din = 32'h0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (HWInt == 6'b0 && n < 12) begin
      tick();
      n++;
    end
    check(tag, 32'(HWInt != 6'b0), 32'd1);
  endtask

  task automatic drain();
    irq_src = 6'b0; ack = 1'b0; eret = 1'b0;
    wr(2'd0, 32'h0);
    for (int n = 0; n < 24 && (m_state != 0 || m_pend != 6'b0 || (m_sq0 | m_sq1) != 6'b0); n++) begin
      Addr = 2'd1; WE = 1'b1; Din = 32'h3F;
      ack = (m_state == 1); eret = (m_state == 2);
      tick();
    end
    WE = 1'b0; Din = 32'h0; ack = 1'b0; eret = 1'b0;
    Addr = 2'd2;
    #1;
    check("drain_state", 32'(Dout[5:4]), 32'd0);
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; Addr = '0; WE = 1'b0; Din = '0; ack = 1'b0; eret = 1'b0;
    model_reset();
    #2;
    check("rst_hwint", 32'(HWInt), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    for (int a = 0; a < 4; a++) rd_check("rst_reg", 2'(a), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // level source 1, exact grant latency, ack, eret and re-grant
    wr(2'd0, 32'h07);
    irq_src = 6'h02;
    repeat (LAT - 1) tick();
    check("lat_early", 32'(HWInt), 32'd0);
    tick();
    check("grant_hw", 32'(HWInt), 32'h02);
    check("grant_id", 32'(irq_id), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("serv_hw", 32'(HWInt), 32'd0);
    rd_check("serv_status", 2'd2, 32'h21);
    eret = 1'b1; tick(); eret = 1'b0;
    rd_check("eret_status", 2'd2, 32'h01);
    tick();
    check("regrant_hw", 32'(HWInt), 32'h02);
    drain();

    // simultaneous sources, no preemption by higher priority
    irq_src = 6'h06;
    wr(2'd0, 32'h07);
    wait_grant("simul_grant");
    check("simul_id", 32'(irq_id), 32'd1);
    irq_src = 6'h07;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("nopreempt_id", 32'(irq_id), 32'd1);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    rd_check("nopreempt_status", 2'd2, 32'h21);
    drain();

    // edge mode pulse latches, ack clears
    wr(2'd3, 32'h04);
    wr(2'd0, 32'h04);
    irq_src = 6'h04; tick(); irq_src = 6'h00;
    wait_grant("edge_grant");
    check("edge_id", 32'(irq_id), 32'd2);
    rd_check("edge_pend", 2'd1, 32'h04);
    ack = 1'b1; tick(); ack = 1'b0;
    rd_check("edge_ack_clr", 2'd1, 32'h00);
    eret = 1'b1; tick(); eret = 1'b0;
    drain();

    // withdraw when MASK cleared before ack
    wr(2'd3, 32'h00);
    irq_src = 6'h01;
    wr(2'd0, 32'h01);
    wait_grant("wd_grant");
    check("wd_id", 32'(irq_id), 32'd0);
    wr(2'd0, 32'h00);
    check("wd_still", 32'(HWInt), 32'h01);
    tick();
    check("wd_drop", 32'(HWInt), 32'd0);
    rd_check("wd_status", 2'd2, 32'h00);
    drain();

    // W1C colliding with a new edge keeps the bit; plain W1C clears it
    wr(2'd3, 32'h04);
    irq_src = 6'h04; tick(); irq_src = 6'h00;
    repeat (SYNC + 1) tick();
    rd_check("w1c_pre", 2'd1, 32'h04);
    irq_src = 6'h04;
    repeat (SYNC) tick();
    wr(2'd1, 32'h04);
    rd_check("w1c_vs_edge", 2'd1, 32'h04);
    wr(2'd1, 32'h04);
    rd_check("w1c_clear", 2'd1, 32'h00);

    // W1C on level bits and writes to STATUS are ignored
    wr(2'd3, 32'h00);
    irq_src = 6'h01;
    repeat (LAT) tick();
    wr(2'd1, 32'h01);
    rd_check("w1c_level", 2'd1, 32'h01);
    wr(2'd2, 32'hFFFF_FFFF);
    rd_check("status_ro", 2'd2, 32'h00);
    drain();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) irq_src = 6'($urandom);
      WE   = ($urandom_range(0, 5) == 0);
      Addr = 2'($urandom);
      Din  = $urandom;
      ack  = ($urandom_range(0, 3) == 0);
      eret = ($urandom_range(0, 4) == 0);
      tick();
    end
    WE = 1'b0; ack = 1'b0; eret = 1'b0;
    drain();

    // asynchronous reset mid-service
    wr(2'd3, 32'h00);
    irq_src = 6'h02;
    wr(2'd0, 32'h07);
    wait_grant("rst_pre_grant");
    ack = 1'b1; tick(); ack = 1'b0;
    rd_check("rst_pre_status", 2'd2, 32'h21);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_hwint", 32'(HWInt), 32'd0);
    rd_check("async_status", 2'd2, 32'h00);
    rd_check("async_mask", 2'd0, 32'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 3) tick();
    check("no_grant_wo_mask", 32'(HWInt), 32'd0);
    wr(2'd0, 32'h02);
    wait_grant("post_rst_grant");
    check("post_rst_id", 32'(irq_id), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
